// File: rtl/shift_unit_seq.sv
// Sequential shifter/rotator. It shifts by at most STEP bit positions per clock
// until the requested amount has been applied, then pulses done for one cycle.
//
// Ports:
//   clock   sole clock, rising edge
//   clear   asynchronous active-high reset
//   start   operation request, sampled only while idle
//   op      000 SHR, 001 SHRA, 010 SHL, 011 ROR, 100 ROL, others illegal
//   B       operand to shift
//   shamt   shift amount, 0 to WIDTH-1
//   busy    high while an operation is in flight (state not idle)
//   done    one-cycle completion pulse
//   err     illegal-op flag, valid while done is high
//   result  registered result, held between operations
module shift_unit_seq #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned STEP  = 1,
    localparam int unsigned SW   = $clog2(WIDTH)
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] B,
    input  logic [SW-1:0]    shamt,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [WIDTH-1:0] result
);

    typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   work_q, work_d;
    logic [SW-1:0]      cnt_q, cnt_d;
    logic [2:0]         op_q, op_d;
    logic [WIDTH-1:0]   result_q, result_d;

    logic [SW-1:0]      k;        // positions shifted this cycle
    logic [SW:0]        kc;       // WIDTH - k, the wrap-around distance for rotates
    logic [WIDTH-1:0]   shifted;

    // k = min(STEP, remaining); remaining never exceeds WIDTH-1, so k fits in SW bits.
    always_comb begin
        k = SW'(STEP);
        if (32'(cnt_q) < STEP) begin
            k = cnt_q;
        end
        kc = (SW+1)'(WIDTH) - {1'b0, k};
    end

    // One shift step under the latched op. k is at least 1 whenever this is used,
    // so kc stays below WIDTH. Illegal ops leave the operand untouched.
    always_comb begin
        shifted = work_q;
        case (op_q)
            3'b000:  shifted = work_q >> k;
            3'b001:  shifted = $unsigned($signed(work_q) >>> k);
            3'b010:  shifted = work_q << k;
            3'b011:  shifted = (work_q >> k) | (work_q << kc);
            3'b100:  shifted = (work_q << k) | (work_q >> kc);
            default: shifted = work_q;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        work_d   = work_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        result_d = result_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    work_d = B;
                    cnt_d  = shamt;
                    op_d   = op;
                    if (shamt != '0) begin
                        state_d = StShift;
                    end else begin
                        // Zero shift: go straight to done with the operand as result.
                        state_d  = StDone;
                        result_d = B;
                    end
                end
            end
            StShift: begin
                work_d = shifted;
                cnt_d  = cnt_q - k;
                if (cnt_q == k) begin
                    state_d  = StDone;
                    result_d = shifted;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state_q  <= StIdle;
            work_q   <= '0;
            cnt_q    <= '0;
            op_q     <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            work_q   <= work_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            result_q <= result_d;
        end
    end

    assign busy   = (state_q != StIdle);
    assign done   = (state_q == StDone);
    assign err    = (state_q == StDone) && (op_q > 3'b100);
    assign result = result_q;

endmodule
